// File: rtl/result_latch_ctrl.sv
// Result latch between converter and SPI shifter: holds a stable frame on the
// st* outputs while the host is clocking it out, and queues one newer frame.
module result_latch_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        done,
    input  logic [31:0] pwmNA,
    input  logic [31:0] pwmNB,
    input  logic [31:0] pwmPA,
    input  logic [31:0] pwmPB,
    input  logic [11:0] rundown,
    input  logic [7:0]  N64,
    input  logic [7:0]  P8,
    input  logic [7:0]  N1,
    input  logic        ovr_clr,
    output logic [31:0] stpwmNA,
    output logic [31:0] stpwmNB,
    output logic [31:0] stpwmPA,
    output logic [31:0] stpwmPB,
    output logic [11:0] strundown,
    output logic [7:0]  stN64,
    output logic [7:0]  stP8,
    output logic [7:0]  stN1,
    output logic        drdy,
    output logic        overrun,
    output logic [7:0]  frame
);

    typedef struct packed {
        logic [31:0] pwmNA;
        logic [31:0] pwmNB;
        logic [31:0] pwmPA;
        logic [31:0] pwmPB;
        logic [11:0] rundown;
        logic [7:0]  N64;
        logic [7:0]  P8;
        logic [7:0]  N1;
    } result_t;

    typedef enum logic [1:0] {IDLE, READY, XFER, PEND} state_t;

    state_t  state, state_nxt;
    result_t raw, st, shadow;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic cs_s, cs_prev, cs_fall, cs_rise;
    logic commit_raw, commit_shadow, capture, set_ovr, clr_drdy;

    assign raw = '{pwmNA: pwmNA, pwmNB: pwmNB, pwmPA: pwmPA, pwmPB: pwmPB,
                   rundown: rundown, N64: N64, P8: P8, N1: N1};

    // Synchroniser resets to "idle" so a low cs at reset release is seen as a
    // fresh falling edge rather than lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync <= '1;
            cs_prev <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs};
            cs_prev <= cs_s;
        end
    end

    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign cs_fall = cs_prev & ~cs_s;
    assign cs_rise = ~cs_prev & cs_s;

    // Handshake: done is a one-cycle valid with no back-pressure; the host
    // consumes a frame by a full cs low period, and drdy drops on cs_fall.
    always_comb begin
        state_nxt     = state;
        commit_raw    = 1'b0;
        commit_shadow = 1'b0;
        capture       = 1'b0;
        set_ovr       = 1'b0;
        clr_drdy      = 1'b0;
        case (state)
            IDLE, READY: begin
                if (cs_fall) begin
                    clr_drdy  = 1'b1;
                    capture   = done;
                    state_nxt = done ? PEND : XFER;
                end else if (done) begin
                    commit_raw = 1'b1;
                    set_ovr    = (state == READY);
                    state_nxt  = READY;
                end
            end
            XFER: begin
                if (cs_rise) begin
                    commit_raw = done;
                    state_nxt  = done ? READY : IDLE;
                end else if (done) begin
                    capture   = 1'b1;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                set_ovr = done;
                if (cs_rise) begin
                    commit_raw    = done;
                    commit_shadow = ~done;
                    state_nxt     = READY;
                end else begin
                    capture = done;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            st      <= '0;
            shadow  <= '0;
            frame   <= 8'd0;
            drdy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) shadow <= raw;
            if (commit_raw || commit_shadow) begin
                st    <= commit_raw ? raw : shadow;
                frame <= frame + 8'd1;
                drdy  <= 1'b1;
            end else if (clr_drdy) begin
                drdy <= 1'b0;
            end
            if (set_ovr)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    assign stpwmNA   = st.pwmNA;
    assign stpwmNB   = st.pwmNB;
    assign stpwmPA   = st.pwmPA;
    assign stpwmPB   = st.pwmPB;
    assign strundown = st.rundown;
    assign stN64     = st.N64;
    assign stP8      = st.P8;
    assign stN1      = st.N1;

endmodule
